// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding, load-use bubble insertion
// and ALU operand selection.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RFW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RFW-1:0]  id_rs1,
  input  logic [RFW-1:0]  id_rs2,
  input  logic [RFW-1:0]  id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_src_a_pc,
  input  logic            id_src_b_imm,
  input  logic            id_uses_rs2,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [RFW-1:0]  exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RFW-1:0]  memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            load_use_stall,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_pc,
  output logic [RFW-1:0]  ex_rd,
  output logic [XLEN-1:0] ex_store_data
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            src_a_pc;
    logic            src_b_imm;
    logic [3:0]      alu_ctrl;
    logic [RFW-1:0]  rd;
    logic [RFW-1:0]  rs1;
    logic [RFW-1:0]  rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } slot_t;

  slot_t slot_q, slot_d, id_slot;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.reg_write = id_reg_write;
    id_slot.mem_read  = id_mem_read;
    id_slot.mem_write = id_mem_write;
    id_slot.src_a_pc  = id_src_a_pc;
    id_slot.src_b_imm = id_src_b_imm;
    id_slot.alu_ctrl  = id_alu_ctrl;
    id_slot.rd        = id_rd;
    id_slot.rs1       = id_rs1;
    id_slot.rs2       = id_rs2;
    id_slot.pc        = id_pc;
    id_slot.rs1_data  = id_rs1_data;
    id_slot.rs2_data  = id_rs2_data;
    id_slot.imm       = id_imm;
  end

  assign load_use_stall = slot_q.valid && slot_q.mem_read && (slot_q.rd != '0) && id_valid &&
                          ((id_rs1 == slot_q.rd) || (id_uses_rs2 && (id_rs2 == slot_q.rd)));

  // Stall outranks the hazard bubble so a held load is never dropped from EX.
  always_comb begin
    slot_d = slot_q;
    if (flush) begin
      slot_d = '0;
    end else if (!stall) begin
      slot_d = load_use_stall ? '0 : id_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = slot_q.rs1_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == slot_q.rs1)) begin
      fwd_rs1 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == slot_q.rs1)) begin
      fwd_rs1 = memwb_result;
    end
  end

  always_comb begin
    fwd_rs2 = slot_q.rs2_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == slot_q.rs2)) begin
      fwd_rs2 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == slot_q.rs2)) begin
      fwd_rs2 = memwb_result;
    end
  end

  assign alu_a         = slot_q.src_a_pc  ? slot_q.pc  : fwd_rs1;
  assign alu_b         = slot_q.src_b_imm ? slot_q.imm : fwd_rs2;
  assign alu_ctrl      = slot_q.alu_ctrl;
  assign ex_valid      = slot_q.valid;
  assign ex_reg_write  = slot_q.reg_write;
  assign ex_mem_read   = slot_q.mem_read;
  assign ex_mem_write  = slot_q.mem_write;
  assign ex_pc         = slot_q.pc;
  assign ex_rd         = slot_q.rd;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// against a slot-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_src_a_pc, id_src_b_imm, id_uses_rs2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use_stall;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RFW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl), .id_src_a_pc(id_src_a_pc),
    .id_src_b_imm(id_src_b_imm), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_store_data(ex_store_data)
  );

  // Reference model: the instruction currently occupying EX.
  typedef struct {
    logic        valid, rw, mr, mw, sa, sb;
    logic [3:0]  ctrl;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, d1, d2, imm;
  } mslot_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_ctrl = 0;
    id_src_a_pc = 0; id_src_b_imm = 0; id_uses_rs2 = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
    return rf;
  endfunction

  task automatic test_reset();
    clear_inputs();
    id_valid = 1; id_pc = 32'h100; id_rd = 5'd4; id_reg_write = 1;
    tick();
    n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", ex_valid); end
    #2 rst_n = 0;
    #1;
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", ex_valid); end
    n_vec++; if (ex_pc !== 32'h0) begin n_err++; $display("FAIL rst_async_pc: got %h want 0", ex_pc); end
    n_vec++; if (ex_rd !== 5'd0 || ex_reg_write !== 1'b0) begin n_err++; $display("FAIL rst_async_ctl: got rd=%0d rw=%b want 0/0", ex_rd, ex_reg_write); end
    n_vec++; if (load_use_stall !== 1'b0) begin n_err++; $display("FAIL rst_lus: got %b want 0", load_use_stall); end
    rst_n = 1;
    #1;
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_valid: got %b want 0", ex_valid); end
    tick();
    n_vec++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin n_err++; $display("FAIL rst_first_capture: got v=%b pc=%h want 1/100", ex_valid, ex_pc); end
  endtask

  task automatic test_addi();
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd1; id_rs1_data = 32'd5; id_imm = 32'd7; id_src_b_imm = 1;
    id_alu_ctrl = 4'd0; id_rd = 5'd2; id_reg_write = 1;
    tick();
    n_vec++; if (alu_a !== 32'd5) begin n_err++; $display("FAIL addi_a: got %h want 5", alu_a); end
    n_vec++; if (alu_b !== 32'd7) begin n_err++; $display("FAIL addi_b: got %h want 7", alu_b); end
    n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd2 || alu_ctrl !== 4'd0) begin n_err++; $display("FAIL addi_ctl: got v=%b rd=%0d op=%0d want 1/2/0", ex_valid, ex_rd, alu_ctrl); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd3; id_rs1_data = 32'h11; id_rs2 = 5'd3; id_rs2_data = 32'h22;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'hBB;
    #1;
    n_vec++; if (alu_a !== 32'hAA) begin n_err++; $display("FAIL fwd_exmem_a: got %h want aa", alu_a); end
    n_vec++; if (alu_b !== 32'hAA) begin n_err++; $display("FAIL fwd_exmem_b: got %h want aa", alu_b); end
    exmem_reg_write = 0;
    #1;
    n_vec++; if (alu_a !== 32'hBB) begin n_err++; $display("FAIL fwd_memwb_a: got %h want bb", alu_a); end
    memwb_reg_write = 0;
    #1;
    n_vec++; if (alu_a !== 32'h11) begin n_err++; $display("FAIL fwd_none_a: got %h want 11", alu_a); end
    id_rs1 = 5'd0; id_rs1_data = 32'h55;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd0; memwb_reg_write = 1; memwb_rd = 5'd0;
    #1;
    n_vec++; if (alu_a !== 32'h55) begin n_err++; $display("FAIL fwd_x0: got %h want 55", alu_a); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_rd = 5'd5; id_mem_read = 1; id_reg_write = 1; id_rs1 = 5'd1;
    tick();
    id_mem_read = 0; id_rd = 5'd7; id_rs1 = 5'd5; id_rs1_data = 32'hDEAD;
    id_rs2 = 5'd6; id_uses_rs2 = 1;
    #1;
    n_vec++; if (load_use_stall !== 1'b1) begin n_err++; $display("FAIL lu_detect: got %b want 1", load_use_stall); end
    tick();
    n_vec++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got v=%b rw=%b want 0/0", ex_valid, ex_reg_write); end
    n_vec++; if (load_use_stall !== 1'b0) begin n_err++; $display("FAIL lu_clear: got %b want 0", load_use_stall); end
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h0;
    tick();
    exmem_reg_write = 0; exmem_rd = 5'd0;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h77;
    #1;
    n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin n_err++; $display("FAIL lu_enter: got v=%b rd=%0d want 1/7", ex_valid, ex_rd); end
    n_vec++; if (alu_a !== 32'h77) begin n_err++; $display("FAIL lu_fwd: got %h want 77", alu_a); end
  endtask

  task automatic test_flush_stall();
    clear_inputs();
    id_valid = 1; id_pc = 32'h40; id_rd = 5'd9; id_reg_write = 1;
    tick();
    flush = 1; stall = 1;
    tick();
    n_vec++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_pc !== 32'h0) begin n_err++; $display("FAIL flush_over_stall: got v=%b rd=%0d pc=%h want 0/0/0", ex_valid, ex_rd, ex_pc); end
    flush = 0; stall = 0;
    id_pc = 32'h80; id_rd = 5'd10; id_alu_ctrl = 4'd9; id_src_a_pc = 1;
    tick();
    stall = 1;
    id_pc = 32'hC0; id_rd = 5'd11; id_alu_ctrl = 4'd3; id_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (ex_valid !== 1'b1 || ex_pc !== 32'h80 || ex_rd !== 5'd10 || alu_ctrl !== 4'd9 || alu_a !== 32'h80) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h rd=%0d op=%0d a=%h want 1/80/10/9/80", i, ex_valid, ex_pc, ex_rd, alu_ctrl, alu_a);
      end
    end
    // Stall while a load-use hazard is pending must keep the load in EX.
    clear_inputs();
    id_valid = 1; id_rd = 5'd5; id_mem_read = 1; id_reg_write = 1;
    tick();
    id_mem_read = 0; id_rd = 5'd6; id_rs1 = 5'd5; stall = 1;
    tick();
    n_vec++; if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || ex_rd !== 5'd5) begin n_err++; $display("FAIL stall_keeps_load: got v=%b mr=%b rd=%0d want 1/1/5", ex_valid, ex_mem_read, ex_rd); end
    n_vec++; if (load_use_stall !== 1'b1) begin n_err++; $display("FAIL stall_lus_persist: got %b want 1", load_use_stall); end
  endtask

  task automatic test_store();
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_uses_rs2 = 1; id_rs2 = 5'd7; id_rs2_data = 32'h99;
    id_imm = 32'h10; id_src_b_imm = 1;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd7; exmem_result = 32'h1234;
    #1;
    n_vec++; if (ex_store_data !== 32'h1234) begin n_err++; $display("FAIL store_data: got %h want 1234", ex_store_data); end
    n_vec++; if (alu_b !== 32'h10 || ex_mem_write !== 1'b1) begin n_err++; $display("FAIL store_b: got b=%h mw=%b want 10/1", alu_b, ex_mem_write); end
  endtask

  task automatic test_random();
    mslot_t m, z;
    logic exp_lus;
    logic [31:0] exp_a, exp_b, exp_sd;
    z = '{default: '0};
    clear_inputs();
    tick();
    m = z;
    for (int c = 0; c < 400; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_imm = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_alu_ctrl = 4'($urandom_range(0, 9));
      id_src_a_pc = 1'($urandom); id_src_b_imm = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
      stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      #1;
      exp_lus = m.valid && m.mr && m.rd != 0 && id_valid &&
                (id_rs1 == m.rd || (id_uses_rs2 && id_rs2 == m.rd));
      exp_a  = m.sa ? m.pc : ref_fwd(m.rs1, m.d1);
      exp_sd = ref_fwd(m.rs2, m.d2);
      exp_b  = m.sb ? m.imm : exp_sd;
      n_vec++; if (load_use_stall !== exp_lus) begin n_err++; $display("FAIL rnd_lus[%0d]: got %b want %b", c, load_use_stall, exp_lus); end
      n_vec++; if (alu_a !== exp_a) begin n_err++; $display("FAIL rnd_a[%0d]: got %h want %h", c, alu_a, exp_a); end
      n_vec++; if (alu_b !== exp_b) begin n_err++; $display("FAIL rnd_b[%0d]: got %h want %h", c, alu_b, exp_b); end
      n_vec++; if (ex_store_data !== exp_sd) begin n_err++; $display("FAIL rnd_sd[%0d]: got %h want %h", c, ex_store_data, exp_sd); end
      n_vec++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, alu_ctrl, ex_pc} !==
                   {m.valid, m.rw, m.mr, m.mw, m.rd, m.ctrl, m.pc}) begin
        n_err++; $display("FAIL rnd_ctl[%0d]: got v=%b rw=%b mr=%b mw=%b rd=%0d op=%0d pc=%h want %b/%b/%b/%b/%0d/%0d/%h",
          c, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, alu_ctrl, ex_pc,
          m.valid, m.rw, m.mr, m.mw, m.rd, m.ctrl, m.pc);
      end
      if (flush) m = z;
      else if (!stall) begin
        if (exp_lus) m = z;
        else m = '{valid: id_valid, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
                   sa: id_src_a_pc, sb: id_src_b_imm, ctrl: id_alu_ctrl, rd: id_rd,
                   rs1: id_rs1, rs2: id_rs2, pc: id_pc, d1: id_rs1_data, d2: id_rs2_data,
                   imm: id_imm};
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    id_valid = 1; id_rs1 = 5'd1;
    #12;
    n_vec++; if (ex_valid !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin n_err++; $display("FAIL init_reset: got v=%b a=%h b=%h want 0/0/0", ex_valid, alu_a, alu_b); end
    n_vec++; if (load_use_stall !== 1'b0) begin n_err++; $display("FAIL init_lus: got %b want 0", load_use_stall); end
    rst_n = 1;
    test_reset();
    test_addi();
    test_forwarding();
    test_load_use();
    test_flush_stall();
    test_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
